// File: rtl/spi_slave_regs.sv
// spi_slave_regs: SPI mode-0 (CPOL=0, CPHA=0) slave fronting a DEPTH x 8-bit
// register file. SPI pins are oversampled in the clk_i domain.
//   clk_i, rst_i      system clock, synchronous active-low reset
//   sck_i, ss_ni,     SPI clock, select (active low), master-out data
//   mosi_i
//   miso_o            slave-out data, MSB first (0 while idle)
//   rd_addr_i/        local read port, one cycle latency
//   rd_data_o
//   wr_strobe_o,      one-cycle pulse per SPI register write, with the
//   wr_addr_o,        written address and data
//   wr_data_o
//   abort_o           one-cycle pulse when a frame ends mid-byte
// Frame: command byte {RW, ignored, addr}, then data bytes at addr, addr+1, ...
// wrapping mod DEPTH. ID is returned during the command byte.
module spi_slave_regs #(
  parameter int          DEPTH  = 16,
  parameter int          ADDR_W = 4,
  parameter logic [7:0]  ID     = 8'hA5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              sck_i,
  input  logic              ss_ni,
  input  logic              mosi_i,
  output logic              miso_o,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [7:0]        rd_data_o,
  output logic              wr_strobe_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [7:0]        wr_data_o,
  output logic              abort_o
);

  typedef enum logic [1:0] {S_IDLE, S_CMD, S_DATA} state_t;
  state_t r_state, w_state_nxt;

  logic [1:0]  r_sck_s, r_ss_s, r_mosi_s;
  logic        r_sck_d, r_ss_d;
  logic [2:0]  r_bit_cnt;
  logic [7:0]  r_rx, r_tx;
  logic        r_rw;
  logic [ADDR_W-1:0] r_addr;
  logic [DEPTH-1:0][7:0] r_regs;

  logic        r_miso, r_wr_strobe, r_abort;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [7:0]  r_wr_data, r_rd_data;

  logic        w_sck_rise, w_sck_fall, w_ss_fall, w_ss_rise, w_byte_done;
  logic [7:0]  w_rx_next;
  logic [ADDR_W-1:0] w_cmd_addr;

  assign w_sck_rise  = r_sck_s[1] & ~r_sck_d;
  assign w_sck_fall  = ~r_sck_s[1] & r_sck_d;
  assign w_ss_fall   = ~r_ss_s[1] & r_ss_d;
  assign w_ss_rise   = r_ss_s[1] & ~r_ss_d;
  assign w_rx_next   = {r_rx[6:0], r_mosi_s[1]};
  assign w_byte_done = w_sck_rise && (r_bit_cnt == 3'd7);
  assign w_cmd_addr  = w_rx_next[ADDR_W-1:0];

  assign miso_o      = r_miso;
  assign rd_data_o   = r_rd_data;
  assign wr_strobe_o = r_wr_strobe;
  assign wr_addr_o   = r_wr_addr;
  assign wr_data_o   = r_wr_data;
  assign abort_o     = r_abort;

  always_ff @(posedge clk_i) begin
    if (!rst_i) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_ss_fall) w_state_nxt = S_CMD;
      S_CMD:   if (w_ss_rise) w_state_nxt = S_IDLE;
               else if (w_byte_done) w_state_nxt = S_DATA;
      S_DATA:  if (w_ss_rise) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      // ss history resets as "already low": a frame in progress at reset
      // release produces no falling edge, so it is ignored until ss_ni rises.
      r_sck_s     <= '0;
      r_ss_s      <= '0;
      r_mosi_s    <= '0;
      r_sck_d     <= 1'b0;
      r_ss_d      <= 1'b0;
      r_bit_cnt   <= '0;
      r_rx        <= '0;
      r_tx        <= '0;
      r_rw        <= 1'b0;
      r_addr      <= '0;
      r_regs      <= '0;
      r_miso      <= 1'b0;
      r_wr_strobe <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_abort     <= 1'b0;
      r_rd_data   <= '0;
    end else begin
      r_sck_s     <= {r_sck_s[0], sck_i};
      r_ss_s      <= {r_ss_s[0], ss_ni};
      r_mosi_s    <= {r_mosi_s[0], mosi_i};
      r_sck_d     <= r_sck_s[1];
      r_ss_d      <= r_ss_s[1];
      r_wr_strobe <= 1'b0;
      r_abort     <= 1'b0;
      // Reads the pre-write value when an SPI write lands in the same cycle.
      r_rd_data   <= r_regs[rd_addr_i];

      if (r_state == S_IDLE) begin
        if (w_ss_fall) begin
          // ID[7] goes straight to the pin; the remaining bits shift on falls.
          r_miso    <= ID[7];
          r_tx      <= {ID[6:0], 1'b0};
          r_bit_cnt <= '0;
        end
      end else if (w_ss_rise) begin
        r_abort   <= (r_bit_cnt != 3'd0);
        r_bit_cnt <= '0;
        r_miso    <= 1'b0;
      end else if (w_sck_rise) begin
        r_rx      <= w_rx_next;
        r_bit_cnt <= r_bit_cnt + 3'd1;
        if (w_byte_done) begin
          if (r_state == S_CMD) begin
            r_rw <= w_rx_next[7];
            if (w_rx_next[7]) begin
              r_tx   <= r_regs[w_cmd_addr];
              r_addr <= w_cmd_addr + ADDR_W'(1);
            end else begin
              r_tx   <= '0;
              r_addr <= w_cmd_addr;
            end
          end else if (r_rw) begin
            r_tx   <= r_regs[r_addr];
            r_addr <= r_addr + ADDR_W'(1);
          end else begin
            r_regs[r_addr] <= w_rx_next;
            r_wr_strobe    <= 1'b1;
            r_wr_addr      <= r_addr;
            r_wr_data      <= w_rx_next;
            r_addr         <= r_addr + ADDR_W'(1);
          end
        end
      end else if (w_sck_fall) begin
        // r_tx holds the bits not yet driven; a byte loaded on the 8th rise
        // therefore shows its MSB at the very next fall.
        r_miso <= r_tx[7];
        r_tx   <= {r_tx[6:0], 1'b0};
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_regs.sv
module tb_spi_slave_regs;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic clk = 1'b0, rst_n = 1'b0, sck = 1'b0, ss_n = 1'b1, mosi = 1'b0;
  logic miso;
  logic [ADDR_W-1:0] rd_addr = '0;
  logic [7:0] rd_data;
  logic wr_strobe, abort;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0] wr_data;

  spi_slave_regs #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .ID(8'hA5)) dut (
    .clk_i(clk), .rst_i(rst_n), .sck_i(sck), .ss_ni(ss_n), .mosi_i(mosi),
    .miso_o(miso), .rd_addr_i(rd_addr), .rd_data_o(rd_data),
    .wr_strobe_o(wr_strobe), .wr_addr_o(wr_addr), .wr_data_o(wr_data),
    .abort_o(abort)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Observed write events and abort pulses.
  logic [11:0] got_wr_q[$];
  int abort_cnt = 0;
  always @(negedge clk) begin
    if (wr_strobe) got_wr_q.push_back({wr_addr, wr_data});
    if (abort) abort_cnt++;
  end

  // Reference model: register array and per-frame expectations.
  logic [7:0]  mregs[DEPTH];
  logic [7:0]  tx_q[$], rx_q[$], exp_rx_q[$];
  logic [11:0] exp_wr_q[$];
  logic        exp_abort;

  task automatic model_frame(input int nbits);
    int nb;
    logic [ADDR_W-1:0] a;
    logic rd;
    nb = nbits / 8;
    exp_rx_q.delete();
    exp_wr_q.delete();
    exp_abort = (nbits % 8) != 0;
    if (nb == 0) return;
    exp_rx_q.push_back(8'hA5);
    rd = tx_q[0][7];
    a  = tx_q[0][ADDR_W-1:0];
    for (int i = 1; i < nb; i++) begin
      if (rd) exp_rx_q.push_back(mregs[a]);
      else begin
        exp_rx_q.push_back(8'h00);
        mregs[a] = tx_q[i];
        exp_wr_q.push_back({a, tx_q[i]});
      end
      a = a + 1'b1;
    end
  endtask

  // One mode-0 bit: mosi set while sck low, miso sampled just before the rise.
  task automatic spi_bit(input logic mo, output logic mi);
    mosi = mo;
    repeat (8) @(negedge clk);
    mi = miso;
    sck = 1'b1;
    repeat (8) @(negedge clk);
    sck = 1'b0;
  endtask

  task automatic spi_xfer(input int nbits);
    logic [7:0] b;
    logic mi;
    b = '0;
    rx_q.delete();
    @(negedge clk);
    ss_n = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      spi_bit(tx_q[i/8][7 - (i%8)], mi);
      b = {b[6:0], mi};
      if (i % 8 == 7) rx_q.push_back(b);
    end
    repeat (8) @(negedge clk);
    ss_n = 1'b1;
    repeat (12) @(negedge clk);
  endtask

  // Runs a frame from tx_q and checks it against the model.
  task automatic run_frame(input string tag, input int nbits);
    got_wr_q.delete();
    abort_cnt = 0;
    model_frame(nbits);
    spi_xfer(nbits);
    chk({tag, " rx count"}, rx_q.size(), exp_rx_q.size());
    for (int i = 0; i < exp_rx_q.size() && i < rx_q.size(); i++)
      chk($sformatf("%s rx byte %0d", tag, i), rx_q[i], exp_rx_q[i]);
    chk({tag, " wr count"}, got_wr_q.size(), exp_wr_q.size());
    for (int i = 0; i < exp_wr_q.size() && i < got_wr_q.size(); i++)
      chk($sformatf("%s wr event %0d", tag, i), got_wr_q[i], exp_wr_q[i]);
    chk({tag, " abort"}, abort_cnt, exp_abort ? 1 : 0);
  endtask

  typedef struct packed {
    logic [31:0] nbits;
    logic [23:0] tx;
    logic [23:0] exp_rx;
    logic [31:0] nrx;
    logic [31:0] nwr;
    logic        abrt;
  } vec_t;

  vec_t vecs[7];

  initial begin
    logic mi;
    logic [7:0] b;
    int nb, nbits;

    vecs[0] = '{32'd8,  24'h030000, 24'hA50000, 32'd1, 32'd0, 1'b0};
    vecs[1] = '{32'd24, 24'h025AC3, 24'hA50000, 32'd3, 32'd2, 1'b0};
    vecs[2] = '{32'd24, 24'h820000, 24'hA55AC3, 32'd3, 32'd0, 1'b0};
    vecs[3] = '{32'd24, 24'h0F1122, 24'hA50000, 32'd3, 32'd2, 1'b0};
    vecs[4] = '{32'd24, 24'h8F0000, 24'hA51122, 32'd3, 32'd0, 1'b0};
    vecs[5] = '{32'd13, 24'h04FF00, 24'hA50000, 32'd1, 32'd0, 1'b1};
    vecs[6] = '{32'd16, 24'h840000, 24'hA50000, 32'd2, 32'd0, 1'b0};

    for (int i = 0; i < DEPTH; i++) mregs[i] = 8'h00;

    // Reset state
    repeat (4) @(negedge clk);
    chk("reset miso", miso, 1'b0);
    chk("reset rd_data", rd_data, 8'h00);
    chk("reset wr_strobe", wr_strobe, 1'b0);
    chk("reset wr_addr", wr_addr, '0);
    chk("reset wr_data", wr_data, 8'h00);
    chk("reset abort", abort, 1'b0);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);

    // Directed table
    foreach (vecs[v]) begin
      tx_q.delete();
      for (int k = 0; k < 3; k++) tx_q.push_back(vecs[v].tx[23 - 8*k -: 8]);
      run_frame($sformatf("vec%0d", v), int'(vecs[v].nbits));
      chk($sformatf("vec%0d tbl nrx", v), rx_q.size(), vecs[v].nrx);
      for (int k = 0; k < int'(vecs[v].nrx) && k < rx_q.size(); k++)
        chk($sformatf("vec%0d tbl rx %0d", v, k), rx_q[k], vecs[v].exp_rx[23 - 8*k -: 8]);
      chk($sformatf("vec%0d tbl nwr", v), got_wr_q.size(), vecs[v].nwr);
      chk($sformatf("vec%0d tbl abort", v), abort_cnt, {31'd0, vecs[v].abrt});
    end

    // Local read port, one cycle latency
    rd_addr = 4'd3;
    @(negedge clk);
    chk("local rd reg3", rd_data, 8'hC3);
    rd_addr = 4'd15;
    @(negedge clk);
    chk("local rd reg15", rd_data, 8'h11);
    rd_addr = 4'd4;
    @(negedge clk);
    chk("local rd reg4 after abort", rd_data, 8'h00);

    // Randomised frames against the model
    for (int f = 0; f < 24; f++) begin
      nb = $urandom_range(1, 4);
      nbits = 8 * nb;
      if ($urandom_range(0, 3) == 0) nbits = nbits + $urandom_range(1, 7);
      tx_q.delete();
      for (int k = 0; k < nb + 1; k++) tx_q.push_back(8'($urandom));
      run_frame($sformatf("rnd%0d", f), nbits);
    end
    for (int a = 0; a < DEPTH; a++) begin
      rd_addr = ADDR_W'(a);
      @(negedge clk);
      chk($sformatf("sweep reg%0d", a), rd_data, mregs[a]);
    end

    // Mid-frame reset during a read frame
    got_wr_q.delete();
    abort_cnt = 0;
    b = 8'h82;
    ss_n = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < 8; i++) spi_bit(b[7-i], mi);
    for (int i = 0; i < 3; i++) spi_bit(1'b0, mi);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < DEPTH; i++) mregs[i] = 8'h00;
    @(negedge clk);
    chk("midreset miso", miso, 1'b0);
    rd_addr = 4'd3;
    repeat (2) @(negedge clk);
    chk("midreset reg3 cleared", rd_data, 8'h00);
    b = '0;
    for (int i = 0; i < 5; i++) begin
      spi_bit(1'b1, mi);
      b = {b[6:0], mi};
    end
    chk("midreset ignored bits", b, 8'h00);
    repeat (8) @(negedge clk);
    ss_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("midreset no abort", abort_cnt, 0);
    chk("midreset no write", got_wr_q.size(), 0);

    tx_q.delete();
    tx_q.push_back(8'h80);
    tx_q.push_back(8'h00);
    run_frame("post-reset", 16);
    chk("post-reset id", rx_q.size() > 0 ? rx_q[0] : 8'hXX, 8'hA5);
    chk("post-reset reg0", rx_q.size() > 1 ? rx_q[1] : 8'hXX, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
